// File: rtl/rotate_operand_sequencer_pkg.sv
// Shared types and constants for the rotate operand sequencer (package rot_pkg).
// Optional result flags are enabled with `define ROT_RESULT_FLAGS_EN.
package rot_pkg;

  localparam int ROT_W     = 32;
  localparam int ROT_AMT_W = 5;
  localparam int ROT_OPS_W = 16;

  localparam logic ROT_DIR_R = 1'b0;
  localparam logic ROT_DIR_L = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } rot_state_e;

endpackage

// File: rtl/rotate_operand_sequencer_if.sv
// Bus, rotator and result signals of the rotate operand sequencer.
// ROT_RESULT_FLAGS_EN adds the out_zero/out_msb result flags.
interface rotate_operand_sequencer_if;
  import rot_pkg::*;

  // Handshakes: a beat transfers on the rising edge where valid and ready are
  // both 1; the producer holds data stable while valid is 1 and ready is 0.
  logic [ROT_W-1:0]     bus_in;
  logic                 bus_valid;
  logic                 bus_dir;
  logic                 bus_ready;
  logic [ROT_W-1:0]     rot_data;
  logic [ROT_AMT_W-1:0] rot_amount;
  logic [ROT_W-1:0]     rot_result;
  logic [ROT_W-1:0]     z_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [ROT_OPS_W-1:0] ops_done;
`ifdef ROT_RESULT_FLAGS_EN
  logic                 out_zero;
  logic                 out_msb;

  modport slave (
    input  bus_in, bus_valid, bus_dir, rot_result, out_ready,
    output bus_ready, rot_data, rot_amount, z_out, out_valid, ops_done,
           out_zero, out_msb
  );
  modport master (
    output bus_in, bus_valid, bus_dir, rot_result, out_ready,
    input  bus_ready, rot_data, rot_amount, z_out, out_valid, ops_done,
           out_zero, out_msb
  );
`else
  modport slave (
    input  bus_in, bus_valid, bus_dir, rot_result, out_ready,
    output bus_ready, rot_data, rot_amount, z_out, out_valid, ops_done
  );
  modport master (
    output bus_in, bus_valid, bus_dir, rot_result, out_ready,
    input  bus_ready, rot_data, rot_amount, z_out, out_valid, ops_done
  );
`endif

endinterface

// File: rtl/rotate_operand_sequencer_amount_conv.sv
// Converts a direction and a 5-bit count into the equivalent right-rotate amount.
module rot_amount_conv
  import rot_pkg::*;
(
  input  logic                 dir_i,
  input  logic [ROT_AMT_W-1:0] count_i,
  output logic [ROT_AMT_W-1:0] amount_o
);

  localparam logic [ROT_AMT_W-1:0] AMT_ZERO = '0;

  // Left by n equals right by (32 - n) mod 32; the modular negate keeps 0 at 0.
  assign amount_o = (dir_i == ROT_DIR_L) ? (AMT_ZERO - count_i) : count_i;

endmodule

// File: rtl/rotate_operand_sequencer.sv
// Two-beat operand/count collector driving an external rotate-right unit and holding its result.
// ROT_RESULT_FLAGS_EN adds registered zero/msb flags of the captured result.
module rotate_operand_sequencer
  import rot_pkg::*;
(
  input  logic                       clock,
  input  logic                       clear,
  rotate_operand_sequencer_if.slave  bus_if,
  output logic [1:0]                 state_o
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_COUNT = COUNT;
  localparam logic [1:0] S_EXEC  = EXEC;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]           state_q, state_d;
  logic [ROT_W-1:0]     data_q, data_d;
  logic [ROT_AMT_W-1:0] amount_q, amount_d;
  logic                 dir_q, dir_d;
  logic [ROT_W-1:0]     z_q, z_d;
  logic [ROT_OPS_W-1:0] ops_q, ops_d;
  logic [ROT_AMT_W-1:0] conv_amount;
`ifdef ROT_RESULT_FLAGS_EN
  logic                 zero_q, zero_d;
  logic                 msb_q, msb_d;
`endif

  rot_amount_conv u_conv (
    .dir_i    (dir_q),
    .count_i  (bus_if.bus_in[ROT_AMT_W-1:0]),
    .amount_o (conv_amount)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    amount_d = amount_q;
    dir_d    = dir_q;
    z_d      = z_q;
    ops_d    = ops_q;
`ifdef ROT_RESULT_FLAGS_EN
    zero_d   = zero_q;
    msb_d    = msb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus_if.bus_valid) begin
          data_d  = bus_if.bus_in;
          dir_d   = bus_if.bus_dir;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (bus_if.bus_valid) begin
          amount_d = conv_amount;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        // Rotator inputs have been stable since the count edge; capture now.
        z_d     = bus_if.rot_result;
`ifdef ROT_RESULT_FLAGS_EN
        zero_d  = (bus_if.rot_result == '0);
        msb_d   = bus_if.rot_result[ROT_W-1];
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus_if.out_ready) begin
          ops_d   = ops_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      amount_q <= '0;
      dir_q    <= ROT_DIR_R;
      z_q      <= '0;
      ops_q    <= '0;
`ifdef ROT_RESULT_FLAGS_EN
      zero_q   <= 1'b0;
      msb_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      amount_q <= amount_d;
      dir_q    <= dir_d;
      z_q      <= z_d;
      ops_q    <= ops_d;
`ifdef ROT_RESULT_FLAGS_EN
      zero_q   <= zero_d;
      msb_q    <= msb_d;
`endif
    end
  end

  // Handshake outputs decode state only, so out_ready never reaches bus_ready.
  assign bus_if.bus_ready  = (state_q == S_IDLE) || (state_q == S_COUNT);
  assign bus_if.out_valid  = (state_q == S_DONE);
  assign bus_if.rot_data   = data_q;
  assign bus_if.rot_amount = amount_q;
  assign bus_if.z_out      = z_q;
  assign bus_if.ops_done   = ops_q;
`ifdef ROT_RESULT_FLAGS_EN
  assign bus_if.out_zero   = zero_q;
  assign bus_if.out_msb    = msb_q;
`endif
  assign state_o           = state_q;

endmodule
